// File: rtl/div_requan.sv
// Sequential signed Q2.14 divider: quotient = (dividend << 14) / divisor,
// restoring division one quotient bit per cycle behind a start/done handshake.
module div_requan #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int NUM_W = DATA_WIDTH + FRAC_BITS;
  localparam int CNT_W = $clog2(NUM_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg;
  logic [NUM_W-1:0]      num_reg, q_reg;
  logic [DATA_WIDTH-1:0] den_reg;
  logic [DATA_WIDTH:0]   rem_reg;
  logic                  sign_reg, dz_reg, dvd_neg_reg;
  logic [DATA_WIDTH-1:0] quotient_reg;
  logic                  overflow_reg, dbz_reg;

  logic [DATA_WIDTH-1:0] abs_dividend, abs_divisor;
  logic [DATA_WIDTH:0]   rem_shift, rem_next;
  logic                  rem_ge;
  logic [NUM_W-1:0]      q_next;
  logic                  big_pos, big_neg;
  logic [DATA_WIDTH-1:0] neg_q, res_q;
  logic                  res_o, res_z;

  // Unsigned magnitudes; 0x8000 negates to itself, which reads as 32768.
  assign abs_dividend = dividend[DATA_WIDTH-1] ? -dividend : dividend;
  assign abs_divisor  = divisor[DATA_WIDTH-1]  ? -divisor  : divisor;

  assign rem_shift = {rem_reg[DATA_WIDTH-1:0], num_reg[NUM_W-1]};
  assign rem_ge    = rem_shift >= {1'b0, den_reg};
  assign rem_next  = rem_ge ? rem_shift - {1'b0, den_reg} : rem_shift;
  assign q_next    = {q_reg[NUM_W-2:0], rem_ge};

  // Saturation thresholds: positive limit 32767, negative limit 32768.
  assign big_pos = |q_next[NUM_W-1:DATA_WIDTH-1];
  assign big_neg = (|q_next[NUM_W-1:DATA_WIDTH]) ||
                   (q_next[DATA_WIDTH-1] && (|q_next[DATA_WIDTH-2:0]));
  assign neg_q   = -q_next[DATA_WIDTH-1:0];

  always_comb begin
    res_q = q_next[DATA_WIDTH-1:0];
    res_o = 1'b0;
    res_z = 1'b0;
    if (dz_reg) begin
      res_q = dvd_neg_reg ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      res_z = 1'b1;
    end else if (!sign_reg) begin
      if (big_pos) begin
        res_q = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        res_o = 1'b1;
      end
    end else if (big_neg) begin
      res_q = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      res_o = 1'b1;
    end else begin
      res_q = neg_q;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      num_reg      <= '0;
      q_reg        <= '0;
      den_reg      <= '0;
      rem_reg      <= '0;
      sign_reg     <= 1'b0;
      dz_reg       <= 1'b0;
      dvd_neg_reg  <= 1'b0;
      quotient_reg <= '0;
      overflow_reg <= 1'b0;
      dbz_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          sign_reg    <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
          dvd_neg_reg <= dividend[DATA_WIDTH-1];
          dz_reg      <= (divisor == '0);
          num_reg     <= {abs_dividend, {FRAC_BITS{1'b0}}};
          den_reg     <= abs_divisor;
          rem_reg     <= '0;
          q_reg       <= '0;
          cnt_reg     <= CNT_W'(NUM_W - 1);
        end
        CALC: begin
          rem_reg <= rem_next;
          q_reg   <= q_next;
          num_reg <= {num_reg[NUM_W-2:0], 1'b0};
          cnt_reg <= cnt_reg - 1'b1;
          // Results land on the edge entering DONE so they are valid with done.
          if (cnt_reg == '0) begin
            quotient_reg <= res_q;
            overflow_reg <= res_o;
            dbz_reg      <= res_z;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign quotient    = quotient_reg;
  assign overflow    = overflow_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: doc/div_requan.md
# div_requan

Sequential signed fixed-point divider for the requantization path, operating on the same 16-bit two's-complement Q2.14 format as the requantizer multiplier (1.0 = 0x4000, range −2.0 … +1.99994). It computes quotient = (dividend << 14) / divisor, one quotient bit per cycle. It uses a start/done handshake so the huffman/requantizer control FSM can issue a division and stall until the result is valid. Typical uses are gain normalization and inverse scale factors, where the hardware multiplier cannot be reused.

## Interface
Parameters:
- DATA_WIDTH, 16, operand/result width; fixed at 16, Q2.14.
- FRAC_BITS, 14, fractional bits; fixed at 14.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  16  signed Q2.14; captured on accepted start.
- divisor  input  16  signed Q2.14; captured on accepted start.
- busy  output  1  high from the cycle after accept through the DONE cycle.
- done  output  1  one-cycle pulse; quotient and flags valid.
- quotient  output  16  signed Q2.14 result, held until the next done.
- overflow  output  1  result saturated; valid with done, held.
- div_by_zero  output  1  divisor was 0; valid with done, held.

## Operation
- One clock (clk), synchronous active-high reset (rst), no other clock domains.
- FSM states: IDLE, CALC, DONE.
- IDLE: if start=1, take a snapshot of the operands and go to CALC.
  - Snapshot contents: sign = dividend[15] XOR divisor[15]; |dividend| placed as a 30-bit numerator with 14 zero LSBs; |divisor| as a 16-bit magnitude (0x8000 → 32768); zero-divisor flag.
  - Load the bit counter with 29.
- CALC: restoring division, MSB first, one numerator bit per cycle.
  - Each cycle: shift the partial remainder left and bring in the next bit; if remainder ≥ |divisor|, subtract and shift in quotient bit 1, else shift in 0.
  - Exit to DONE after the bit-0 cycle (30 CALC cycles total).
  - The remainder register is 17 bits so no carry is lost.
- DONE: assert done for one cycle, update the outputs, then return to IDLE.
- Result rules, 30-bit magnitude Q:
  - Divide by zero: quotient = 0x7FFF if dividend[15]=0, else 0x8000; div_by_zero=1, overflow=0. This also applies when the dividend is 0 (result 0x7FFF).
  - Positive result, Q > 32767: quotient = 0x7FFF, overflow=1.
  - Negative result, Q > 32768: quotient = 0x8000, overflow=1.
  - Negative result, Q = 32768: quotient = 0x8000 exactly, overflow=0.
  - Otherwise quotient = sign ? −Q : Q, truncated toward zero; flags 0.
  - A zero result is always 0x0000, never negative zero.
- The divide-by-zero path runs through CALC as normal; its result is overridden in DONE, so latency is uniform.
- start in CALC or DONE is ignored and not queued; the requester must wait for done.
- Operand inputs are don't-care except in the accepted start cycle.

## Timing
- Reset values: busy=0, done=0, quotient=0x0000, overflow=0, div_by_zero=0, state=IDLE, counter=0.
- Accepting start at edge T:
  - busy=1 from cycle T+1.
  - CALC occupies cycles T+1…T+30.
  - DONE at cycle T+31: done=1 and quotient/flags take their new values in that same cycle.
  - busy falls at T+32.
- Fixed latency: 31 cycles from accept to done, independent of operand values.
- Maximum throughput: one division per 32 cycles. A start asserted in cycle T+32 (IDLE) is accepted.
- rst at any cycle, including mid-CALC or DONE:
  - Next cycle is IDLE with all reset values.
  - No done pulse is produced for the aborted operation.
  - A start coincident with rst is ignored.
- quotient, overflow and div_by_zero change only in the DONE cycle or on reset.

## Test plan
- Basic: dividend 0x2000, divisor 0x4000 (0.5/1.0) → done at T+31, quotient 0x2000, flags 0, busy high T+1…T+31.
- Truncation and signs:
  - 0x4000/0x6000 → 0x2AAA.
  - 0xC000/0x6000 → 0xD556.
  - 0xC000/0xA000 → 0x2AAA.
- Saturation edges:
  - 0x4000/0x2000 → 0x7FFF, overflow=1.
  - 0xC000/0x2000 → 0x8000, overflow=0.
  - 0x8000/0xC000 → 0x7FFF, overflow=1.
- Divide by zero:
  - 0x1234/0x0000 → 0x7FFF, div_by_zero=1.
  - 0xF000/0x0000 → 0x8000, div_by_zero=1.
  - Latency still 31 cycles.
- Handshake:
  - start held high continuously → accepts at T and T+32 only.
  - Operands changed during CALC have no effect on the result.
  - Back-to-back results are correct.
- Reset mid-operation: rst at T+10 → busy=0 and quotient=0x0000 next cycle; no done pulse; a new start afterward completes normally in 31 cycles.
